// File: rtl/pending_priority_encoder_if.sv
// Output handshake of pending_priority_encoder: a 1-based index offered on valid/ready.
// Index 0 means "none" and is only ever seen while out_valid is low.
interface pending_priority_encoder_if #(
   parameter int unsigned W = 4
);
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;

   modport master (
      output out_valid,
      output out_idx,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_idx,
      output out_ready
   );
endinterface

// File: rtl/pending_priority_encoder.sv
// Registered priority encoder: request pulses latch into a pending register and are issued
// one at a time as 1-based indices, by fixed priority (highest first) or round-robin.
module pending_priority_encoder #(
   parameter int unsigned N           = 9,
   parameter int unsigned W           = $clog2(N + 1),
   parameter bit          ROUND_ROBIN = 1'b0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N-1:0]                      req_i,
   input  logic [N-1:0]                      mask_i,
   input  logic                              clear_i,
   pending_priority_encoder_if.master        out_if,
   output logic [N-1:0]                      pending_o,
   output logic                              overflow_o
);

   localparam logic [W-1:0] IdxNone = '0;
   localparam logic [W-1:0] IdxLast = W'(N);

   logic [N-1:0] pending_q, pending_d;
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_idx_q, out_idx_d;
   logic         overflow_q, overflow_d;

   logic         accept;
   logic [N-1:0] acc_oh;
   logic [N-1:0] elig;
   logic [W-1:0] sel_idx;

   assign accept = out_valid_q & out_if.out_ready;

   always_comb begin
      acc_oh = '0;
      for (int k = 0; k < int'(N); k++) begin
         acc_oh[k] = accept && (out_idx_q == W'(k + 1));
      end
   end

   // Eligibility uses the pre-update pending set, so same-cycle requests wait one cycle.
   assign elig = pending_q & ~acc_oh & ~mask_i;

   if (ROUND_ROBIN) begin : g_rr
      logic [W-1:0] rr_q, rr_d;

      // Walk downward from rr-1, wrapping 1 -> N, so the last accepted line comes last.
      always_comb begin : rr_search
         int j;
         j       = 0;
         sel_idx = IdxNone;
         for (int i = 1; i <= int'(N); i++) begin
            j = int'(rr_q) - i;
            if (j < 1) begin
               j = j + int'(N);
            end
            if ((sel_idx == IdxNone) && elig[j-1]) begin
               sel_idx = W'(j);
            end
         end
      end

      always_comb begin
         rr_d = rr_q;
         if (accept) begin
            rr_d = out_idx_q;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            rr_q <= IdxLast;
         end else begin
            rr_q <= rr_d;
         end
      end
   end else begin : g_fixed
      // Ascending scan: the last hit is the highest eligible index.
      always_comb begin
         sel_idx = IdxNone;
         for (int k = 0; k < int'(N); k++) begin
            if (elig[k]) begin
               sel_idx = W'(k + 1);
            end
         end
      end
   end

   always_comb begin
      pending_d   = (pending_q & ~acc_oh) | req_i;
      overflow_d  = overflow_q | (|(req_i & pending_q & ~acc_oh));
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;

      if (clear_i) begin
         pending_d   = '0;
         overflow_d  = 1'b0;
         out_valid_d = 1'b0;
         out_idx_d   = IdxNone;
      end else if (!(out_valid_q && !out_if.out_ready)) begin
         // A stalled offer is held untouched; otherwise reload from the current selection.
         out_valid_d = |elig;
         out_idx_d   = sel_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q   <= '0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_idx_q   <= IdxNone;
      end else begin
         pending_q   <= pending_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
      end
   end

   assign out_if.out_valid = out_valid_q;
   assign out_if.out_idx   = out_idx_q;
   assign pending_o        = pending_q;
   assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Bench for pending_priority_encoder: a fixed-priority and a round-robin instance share stimulus
// and are compared against a per-line behavioural model plus directed constant expectations.
module tb_pending_priority_encoder;

   localparam int N = 9;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         clear;
   logic         ready;
   logic [N-1:0] req;
   logic [N-1:0] mask;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pending_priority_encoder_if #(.W(W)) if_fp ();
   pending_priority_encoder_if #(.W(W)) if_rr ();

   assign if_fp.out_ready = ready;
   assign if_rr.out_ready = ready;

   logic [N-1:0] pend_fp, pend_rr;
   logic         ovf_fp, ovf_rr;

   pending_priority_encoder #(.N(N), .W(W), .ROUND_ROBIN(1'b0)) u_fp (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req),
      .mask_i    (mask),
      .clear_i   (clear),
      .out_if    (if_fp),
      .pending_o (pend_fp),
      .overflow_o(ovf_fp)
   );

   pending_priority_encoder #(.N(N), .W(W), .ROUND_ROBIN(1'b1)) u_rr (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req),
      .mask_i    (mask),
      .clear_i   (clear),
      .out_if    (if_rr),
      .pending_o (pend_rr),
      .overflow_o(ovf_rr)
   );

   // Observed outputs, index 0 = fixed priority, 1 = round-robin.
   logic         d_valid [2];
   logic [W-1:0] d_idx   [2];
   logic [N-1:0] d_pend  [2];
   logic         d_ovf   [2];

   assign d_valid[0] = if_fp.out_valid;
   assign d_valid[1] = if_rr.out_valid;
   assign d_idx[0]   = if_fp.out_idx;
   assign d_idx[1]   = if_rr.out_idx;
   assign d_pend[0]  = pend_fp;
   assign d_pend[1]  = pend_rr;
   assign d_ovf[0]   = ovf_fp;
   assign d_ovf[1]   = ovf_rr;

   // Behavioural model state per instance.
   logic [N-1:0] m_pend  [2];
   bit           m_valid [2];
   int           m_idx   [2];
   bit           m_ovf   [2];
   int           m_rr    [2];

   task automatic model_edge();
      for (int m = 0; m < 2; m++) begin
         bit           acc_v;
         int           acc;
         int           sel;
         int           j;
         bit           keep;
         bit           novf;
         logic [N-1:0] np;
         acc_v = m_valid[m] && ready;
         acc   = acc_v ? m_idx[m] : 0;
         sel   = 0;
         for (int i = 1; i <= N; i++) begin
            if (m == 0) begin
               j = N + 1 - i;
            end else begin
               j = m_rr[m] - i;
               if (j < 1) j += N;
            end
            if (sel == 0 && m_pend[m][j-1] && j != acc && !mask[j-1]) sel = j;
         end
         novf = m_ovf[m];
         np   = '0;
         for (int k = 1; k <= N; k++) begin
            keep = m_pend[m][k-1] && (k != acc);
            if (keep && req[k-1]) novf = 1'b1;
            np[k-1] = keep || req[k-1];
         end
         if (rst || clear) begin
            np          = '0;
            novf        = 1'b0;
            m_valid[m]  = 1'b0;
            m_idx[m]    = 0;
         end else if (!(m_valid[m] && !ready)) begin
            m_valid[m] = (sel != 0);
            m_idx[m]   = sel;
         end
         if (rst) m_rr[m] = N;
         else if (acc_v) m_rr[m] = acc;
         m_pend[m] = np;
         m_ovf[m]  = novf;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      req   = '0;
      mask  = '0;
      clear = 1'b0;
      ready = 1'b0;
      rst   = 1'b1;
      tick();
      rst   = 1'b0;
   endtask

   task automatic test_reset();
      req   = '1;
      ready = 1'b1;
      rst   = 1'b1;
      tick();
      rst   = 1'b0;
      req   = '0;
      for (int m = 0; m < 2; m++) begin
         checks++;
         if ({d_valid[m], d_idx[m], d_pend[m], d_ovf[m]} !== {1'b0, {W{1'b0}}, {N{1'b0}}, 1'b0})
         begin
            errors++;
            $display("FAIL reset dut%0d: got v=%0b idx=%0d pend=%h ovf=%0b, expected all zero",
                     m, d_valid[m], d_idx[m], d_pend[m], d_ovf[m]);
         end
      end
   endtask

   task automatic test_fixed_sweep();
      do_reset();
      ready = 1'b1;
      req   = 9'h1FF;
      tick();
      req   = '0;
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (d_pend[m] !== 9'h1FF || d_valid[m] !== 1'b0) begin
            errors++;
            $display("FAIL sweep_latch dut%0d: got pend=%h v=%0b, expected pend=1ff v=0",
                     m, d_pend[m], d_valid[m]);
         end
      end
      for (int s = 0; s < N; s++) begin
         tick();
         checks++;
         if (d_valid[0] !== 1'b1 || d_idx[0] !== W'(9 - s)) begin
            errors++;
            $display("FAIL sweep_fixed step %0d: got v=%0b idx=%0d, expected v=1 idx=%0d",
                     s, d_valid[0], d_idx[0], 9 - s);
         end
         checks++;
         if (d_valid[1] !== 1'b1 || d_idx[1] !== W'((s < 8) ? 8 - s : 9)) begin
            errors++;
            $display("FAIL sweep_rr step %0d: got v=%0b idx=%0d, expected v=1 idx=%0d",
                     s, d_valid[1], d_idx[1], (s < 8) ? 8 - s : 9);
         end
      end
      tick();
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (d_valid[m] !== 1'b0 || d_pend[m] !== '0 || d_idx[m] !== '0) begin
            errors++;
            $display("FAIL sweep_drain dut%0d: got v=%0b idx=%0d pend=%h, expected 0 0 0",
                     m, d_valid[m], d_idx[m], d_pend[m]);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      req = 9'h004;
      tick();
      req = '0;
      tick();
      req  = 9'h100;
      mask = 9'h004;
      for (int s = 0; s < 4; s++) begin
         tick();
         req = '0;
         for (int m = 0; m < 2; m++) begin
            checks++;
            if (d_valid[m] !== 1'b1 || d_idx[m] !== W'(3)) begin
               errors++;
               $display("FAIL stall_hold dut%0d cyc %0d: got v=%0b idx=%0d, expected v=1 idx=3",
                        m, s, d_valid[m], d_idx[m]);
            end
         end
      end
      ready = 1'b1;
      tick();
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (d_valid[m] !== 1'b1 || d_idx[m] !== W'(9)) begin
            errors++;
            $display("FAIL stall_next dut%0d: got v=%0b idx=%0d, expected v=1 idx=9",
                     m, d_valid[m], d_idx[m]);
         end
      end
   endtask

   task automatic test_rr_stream();
      int exp_rr;
      do_reset();
      ready = 1'b1;
      req   = 9'h1FF;
      tick();
      for (int s = 0; s < 20; s++) begin
         tick();
         exp_rr = (s % 9 == 8) ? 9 : 8 - (s % 9);
         checks++;
         if (d_valid[1] !== 1'b1 || d_idx[1] !== W'(exp_rr)) begin
            errors++;
            $display("FAIL rr_stream step %0d: got v=%0b idx=%0d, expected v=1 idx=%0d",
                     s, d_valid[1], d_idx[1], exp_rr);
         end
         checks++;
         if ({d_valid[0], d_idx[0], d_pend[0], d_ovf[0]} !==
             {m_valid[0], W'(m_idx[0]), m_pend[0], m_ovf[0]}) begin
            errors++;
            $display("FAIL rr_stream_fixed step %0d: got v=%0b idx=%0d pend=%h ovf=%0b, expected v=%0b idx=%0d pend=%h ovf=%0b",
                     s, d_valid[0], d_idx[0], d_pend[0], d_ovf[0],
                     m_valid[0], m_idx[0], m_pend[0], m_ovf[0]);
         end
      end
      req = '0;
   endtask

   task automatic test_overflow();
      do_reset();
      req = 9'h010;
      tick();
      req = '0;
      tick();
      req = 9'h010;
      tick();
      req = '0;
      for (int s = 0; s < 3; s++) begin
         for (int m = 0; m < 2; m++) begin
            checks++;
            if (d_ovf[m] !== 1'b1) begin
               errors++;
               $display("FAIL overflow_set dut%0d cyc %0d: got ovf=%0b, expected 1",
                        m, s, d_ovf[m]);
            end
         end
         tick();
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (d_ovf[m] !== 1'b0 || d_pend[m] !== '0 || d_valid[m] !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear dut%0d: got ovf=%0b pend=%h v=%0b, expected 0 0 0",
                     m, d_ovf[m], d_pend[m], d_valid[m]);
         end
      end
   endtask

   task automatic test_race();
      do_reset();
      req = 9'h010;
      tick();
      req = '0;
      tick();
      ready = 1'b1;
      req   = 9'h010;
      tick();
      req   = '0;
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (d_pend[m][4] !== 1'b1 || d_ovf[m] !== 1'b0 || d_valid[m] !== 1'b0) begin
            errors++;
            $display("FAIL race_edge dut%0d: got pend4=%0b ovf=%0b v=%0b, expected 1 0 0",
                     m, d_pend[m][4], d_ovf[m], d_valid[m]);
         end
      end
      tick();
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (d_valid[m] !== 1'b1 || d_idx[m] !== W'(5)) begin
            errors++;
            $display("FAIL race_reissue dut%0d: got v=%0b idx=%0d, expected v=1 idx=5",
                     m, d_valid[m], d_idx[m]);
         end
      end
   endtask

   task automatic test_mask_all();
      do_reset();
      ready = 1'b1;
      mask  = '1;
      req   = 9'h0A5;
      tick();
      req   = '0;
      for (int s = 0; s < 3; s++) begin
         tick();
         for (int m = 0; m < 2; m++) begin
            checks++;
            if (d_valid[m] !== 1'b0 || d_pend[m] !== 9'h0A5) begin
               errors++;
               $display("FAIL mask_all dut%0d cyc %0d: got v=%0b pend=%h, expected v=0 pend=0a5",
                        m, s, d_valid[m], d_pend[m]);
            end
         end
      end
      mask = '0;
      tick();
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (d_valid[m] !== 1'b1 || d_idx[m] !== W'(8)) begin
            errors++;
            $display("FAIL unmask dut%0d: got v=%0b idx=%0d, expected v=1 idx=8",
                     m, d_valid[m], d_idx[m]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      ready = 1'b1;
      req   = 9'h0F0;
      tick();
      req   = '0;
      tick();
      tick();
      ready = 1'b0;
      req   = 9'h0F0;
      tick();
      req   = '0;
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (d_valid[m] !== 1'b1 || d_pend[m] !== 9'h0F0) begin
            errors++;
            $display("FAIL reset_mid_pre dut%0d: got v=%0b pend=%h, expected v=1 pend=0f0",
                     m, d_valid[m], d_pend[m]);
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int m = 0; m < 2; m++) begin
         checks++;
         if ({d_valid[m], d_idx[m], d_pend[m], d_ovf[m]} !== {1'b0, {W{1'b0}}, {N{1'b0}}, 1'b0})
         begin
            errors++;
            $display("FAIL reset_mid dut%0d: got v=%0b idx=%0d pend=%h ovf=%0b, expected all zero",
                     m, d_valid[m], d_idx[m], d_pend[m], d_ovf[m]);
         end
      end
      ready = 1'b1;
      req   = 9'h1F0;
      tick();
      req   = '0;
      tick();
      checks++;
      if (d_valid[1] !== 1'b1 || d_idx[1] !== W'(8)) begin
         errors++;
         $display("FAIL reset_rr_ptr: got v=%0b idx=%0d, expected v=1 idx=8",
                  d_valid[1], d_idx[1]);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int s = 0; s < 600; s++) begin
         req   = N'($urandom & $urandom);
         mask  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         ready = ($urandom_range(0, 2) != 0);
         clear = ($urandom_range(0, 40) == 0);
         rst   = ($urandom_range(0, 80) == 0);
         tick();
         for (int m = 0; m < 2; m++) begin
            checks++;
            if ({d_valid[m], d_idx[m], d_pend[m], d_ovf[m]} !==
                {m_valid[m], W'(m_idx[m]), m_pend[m], m_ovf[m]}) begin
               errors++;
               $display("FAIL random dut%0d step %0d: got v=%0b idx=%0d pend=%h ovf=%0b, expected v=%0b idx=%0d pend=%h ovf=%0b",
                        m, s, d_valid[m], d_idx[m], d_pend[m], d_ovf[m],
                        m_valid[m], m_idx[m], m_pend[m], m_ovf[m]);
            end
         end
      end
      rst   = 1'b0;
      clear = 1'b0;
      req   = '0;
      mask  = '0;
   endtask

   initial begin
      rst   = 1'b1;
      clear = 1'b0;
      ready = 1'b0;
      req   = '0;
      mask  = '0;
      for (int m = 0; m < 2; m++) begin
         m_pend[m]  = '0;
         m_valid[m] = 1'b0;
         m_idx[m]   = 0;
         m_ovf[m]   = 1'b0;
         m_rr[m]    = N;
      end
      test_reset();
      test_fixed_sweep();
      test_stall();
      test_rr_stream();
      test_overflow();
      test_race();
      test_mask_all();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pending_priority_encoder.md
# pending_priority_encoder

Parametrised, registered priority encoder for N single-bit request lines. Request pulses are captured into a pending register, and the block presents one pending line at a time as a 1-based index on a valid/ready output. An accepted index clears its pending bit. Selection is either fixed priority (highest index wins) or round-robin. The block sits between event sources (status strobes, interrupt-style lines) and a sequencer that consumes one event per handshake.

## Interface
- `N`, default 9: number of request lines, 1..31.
- `W`, default `$clog2(N+1)`: index width. Index value 0 means "none"; index k corresponds to `req_i[k-1]`.
- `ROUND_ROBIN`, default 0: 0 selects fixed priority, 1 selects round-robin.

Ports (synchronous reset, active-high):
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset.
- `req_i`, input, N: request pulses; a 1 on any cycle sets the matching pending bit.
- `mask_i`, input, N: 1 excludes that line from selection. A masked line still latches as pending.
- `clear_i`, input, 1: synchronous flush of all pending state.
- `out_valid`, output, 1: `out_idx` holds a valid pending index.
- `out_ready`, input, 1: consumer accepts `out_idx` when asserted together with `out_valid`.
- `out_idx`, output, W: selected index, 1..N. It is 0 whenever `out_valid` is 0.
- `pending_o`, output, N: current pending register.
- `overflow_o`, output, 1: sticky flag, set when a request lands on an already-pending, not-accepted line.

## Operation
- Definitions:
  - `accept` = `out_valid & out_ready`.
  - `acc_oh` = one-hot of `out_idx-1` when `accept`, else 0.
- Pending update: `pending_next = (pending & ~acc_oh) | req_i`, forced to 0 when `clear_i`.
  - A request on the line being accepted in the same cycle re-sets that bit (request wins).
  - `clear_i` wins over `req_i`.
- Eligible set: `elig = pending & ~acc_oh & ~mask_i`. This uses the pre-update `pending`; a request arriving this cycle is not eligible until the next cycle.
- Fixed priority: choose the highest set bit of `elig`.
- Round-robin:
  - Pointer `rr` holds the last accepted index.
  - Search `elig` downward from `rr-1`, wrapping from 1 to N, and take the first set bit.
  - `rr` loads `out_idx` on each `accept`.
- Output register update rule, in priority order:
  1. `rst` or `clear_i`: `out_valid`=0, `out_idx`=0.
  2. `out_valid & ~out_ready`: hold. `out_idx` stays stable even if a higher-priority line arrives or the held line becomes masked.
  3. Otherwise: `out_valid` = `|elig`; `out_idx` = selected index, or 0 if none.
- `overflow_o`:
  - Set when `req_i[k] & pending[k] & ~acc_oh[k]` for any k.
  - Cleared only by `rst` or `clear_i`. If set and clear coincide, clear wins.

## Timing
- Reset values: `pending_o`=0, `out_valid`=0, `out_idx`=0, `overflow_o`=0, `rr`=N (first round-robin search starts at N-1 and wraps to N last).
- Latency: `req_i` asserted in cycle t sets `pending_o` at edge t. `out_valid`/`out_idx` appear at edge t+1, provided the output register was idle.
- Throughput: with `out_ready` held high and multiple lines pending, a new index is issued every cycle. The accepted index is never presented twice, unless it was re-requested in the accept cycle.
- Back-to-back re-request: a line re-requested in its accept cycle becomes eligible one cycle later.
- All lines masked while pending: `out_valid` stays 0 and `pending_o` is retained. Unmasking yields `out_valid` one edge later.
- `rst` or `clear_i` mid-handshake: any un-accepted index is dropped without acknowledgement.

## Test plan
- Fixed priority, N=9: pulse `req_i`=0x1FF for one cycle with `out_ready`=1. Required `out_idx` sequence 9,8,...,1 on consecutive cycles, then `out_valid`=0 and `pending_o`=0.
- Stall stability: `req_i[2]` pending (index 3), `out_ready`=0; then pulse `req_i[8]` and set `mask_i[2]`=1. Required: `out_idx` stays 3 until `out_ready`=1; the next issued index is 9.
- Round-robin, N=9: `req_i`=0x1FF every cycle, `out_ready`=1. Required `out_idx` sequence 8,7,...,1,9,8,... with no line repeated within 9 accepts.
- Overflow: pulse `req_i[4]` twice while `out_ready`=0. Required: `overflow_o`=1 after the second edge and held; `clear_i` pulse returns `overflow_o`, `pending_o` and `out_valid` to 0 at the next edge.
- Accept/re-request race: `out_idx`=5 valid, `out_ready`=1, and `req_i[4]`=1 in the same cycle. Required: `pending_o[4]`=1 after the edge and `overflow_o`=0; index 5 is re-issued one cycle later if it is the highest eligible line.
- Reset mid-operation: assert `rst` while `out_valid`=1 with 0x0F0 pending. Required: all outputs 0 at the next edge; `rr`=N (checked by the first round-robin pick being the highest eligible below N).
